// File: rtl/gcd_axil_slave.sv
// AXI4-Lite register file (A, B, CTRL, RESULT) in front of an iterative
// subtract-based GCD engine that takes one subtraction step per clock.
module gcd_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r, state_nxt_s;
    logic        aw_ready_r, b_valid_r, ar_ready_r, r_valid_r;
    logic [31:0] rdata_r, read_mux_s, ctrl_rd_s;
    logic [31:0] reg_a_r, reg_b_r, result_r;
    logic [31:0] x_r, y_r, x_nxt_s, y_nxt_s, result_nxt_s;
    logic        ie_r;
    logic        wr_accept_s, wr_fire_s, ctrl_wr_s, start_s, clr_s;
    logic [1:0]  wr_addr_s;
    logic        busy_s, done_s;
    logic        unused_s;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    // The write handshake cycle is the one cycle AWREADY/WREADY are high.
    assign wr_accept_s = S_AXI_AWVALID & S_AXI_WVALID & ~aw_ready_r & ~b_valid_r;
    assign wr_fire_s   = aw_ready_r;
    assign wr_addr_s   = S_AXI_AWADDR[3:2];
    assign ctrl_wr_s   = wr_fire_s & (wr_addr_s == 2'd2) & S_AXI_WSTRB[0];
    assign start_s     = ctrl_wr_s & S_AXI_WDATA[0];
    assign clr_s       = ctrl_wr_s & S_AXI_WDATA[2];

    assign busy_s    = (state_r == ST_CALC);
    assign done_s    = (state_r == ST_DONE);
    assign ctrl_rd_s = {28'd0, busy_s, done_s, ie_r, 1'b0};

    assign S_AXI_AWREADY = aw_ready_r;
    assign S_AXI_WREADY  = aw_ready_r;
    assign S_AXI_BVALID  = b_valid_r;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = ar_ready_r;
    assign S_AXI_RVALID  = r_valid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = 2'b00;
    assign irq           = done_s & ie_r;

    assign unused_s = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write address/data acceptance and write response.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_ready_r <= 1'b0;
            b_valid_r  <= 1'b0;
        end else begin
            aw_ready_r <= wr_accept_s;
            if (aw_ready_r) begin
                b_valid_r <= 1'b1;
            end else if (b_valid_r && S_AXI_BREADY) begin
                b_valid_r <= 1'b0;
            end else begin
                b_valid_r <= b_valid_r;
            end
        end
    end

    // Software-visible operand and interrupt-enable registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            reg_a_r <= 32'd0;
            reg_b_r <= 32'd0;
            ie_r    <= 1'b0;
        end else if (wr_fire_s) begin
            case (wr_addr_s)
                2'd0: reg_a_r <= apply_strb(reg_a_r, S_AXI_WDATA, S_AXI_WSTRB);
                2'd1: reg_b_r <= apply_strb(reg_b_r, S_AXI_WDATA, S_AXI_WSTRB);
                2'd2: begin
                    if (S_AXI_WSTRB[0]) begin
                        ie_r <= S_AXI_WDATA[1];
                    end else begin
                        ie_r <= ie_r;
                    end
                end
                default: begin
                end
            endcase
        end else begin
            ie_r <= ie_r;
        end
    end

    // Read data selection; sampled during the ARREADY cycle, so same-cycle writes read old.
    always_comb begin
        read_mux_s = 32'd0;
        case (S_AXI_ARADDR[3:2])
            2'd0:    read_mux_s = reg_a_r;
            2'd1:    read_mux_s = reg_b_r;
            2'd2:    read_mux_s = ctrl_rd_s;
            2'd3:    read_mux_s = result_r;
            default: read_mux_s = 32'd0;
        endcase
    end

    // Read address acceptance and registered read data.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ar_ready_r <= 1'b0;
            r_valid_r  <= 1'b0;
            rdata_r    <= 32'd0;
        end else begin
            ar_ready_r <= S_AXI_ARVALID & ~ar_ready_r & ~r_valid_r;
            if (ar_ready_r) begin
                r_valid_r <= 1'b1;
                rdata_r   <= read_mux_s;
            end else if (r_valid_r && S_AXI_RREADY) begin
                r_valid_r <= 1'b0;
            end else begin
                r_valid_r <= r_valid_r;
            end
        end
    end

    // GCD next-state: START from IDLE/DONE wins over a same-write DONE clear.
    always_comb begin
        state_nxt_s  = state_r;
        x_nxt_s      = x_r;
        y_nxt_s      = y_r;
        result_nxt_s = result_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_CALC;
                    x_nxt_s     = reg_a_r;
                    y_nxt_s     = reg_b_r;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (x_r == 32'd0) begin
                    result_nxt_s = y_r;
                    state_nxt_s  = ST_DONE;
                end else if ((y_r == 32'd0) || (x_r == y_r)) begin
                    result_nxt_s = x_r;
                    state_nxt_s  = ST_DONE;
                end else if (x_r > y_r) begin
                    x_nxt_s = x_r - y_r;
                end else begin
                    y_nxt_s = y_r - x_r;
                end
            end
            ST_DONE: begin
                if (start_s) begin
                    state_nxt_s = ST_CALC;
                    x_nxt_s     = reg_a_r;
                    y_nxt_s     = reg_b_r;
                end else if (clr_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // GCD state and datapath registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r  <= ST_IDLE;
            x_r      <= 32'd0;
            y_r      <= 32'd0;
            result_r <= 32'd0;
        end else begin
            state_r  <= state_nxt_s;
            x_r      <= x_nxt_s;
            y_r      <= y_nxt_s;
            result_r <= result_nxt_s;
        end
    end

endmodule

// File: tb/tb_gcd_axil_slave.sv
// Bench for gcd_axil_slave: directed and randomized AXI-Lite traffic, checked
// every cycle against a transaction-level model of the register map and GCD.
module tb_gcd_axil_slave;

    localparam logic [3:0] ADDR_A      = 4'h0;
    localparam logic [3:0] ADDR_B      = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;
    localparam logic [3:0] ADDR_RESULT = 4'hC;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [3:0]  S_AXI_AWADDR = 4'h0;
    logic [2:0]  S_AXI_AWPROT = 3'b000;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = 32'd0;
    logic [3:0]  S_AXI_WSTRB = 4'h0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [3:0]  S_AXI_ARADDR = 4'h0;
    logic [2:0]  S_AXI_ARPROT = 3'b000;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic        irq;

    gcd_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    int          checks = 0;
    int          errors = 0;
    int          drv_timeouts = 0;
    int          seen_timeouts = 0;
    logic        lit_en = 1'b0;
    logic [31:0] lit_val = 32'd0;

    // Model state, owned by the compare process.
    logic [31:0] m_a = 32'd0, m_b = 32'd0, m_result = 32'd0, m_pend = 32'd0, m_rexp = 32'd0;
    logic        m_ie = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    logic        m_awr = 1'b0, m_bv = 1'b0, m_arr = 1'b0, m_rv = 1'b0;
    logic        n_awr, n_bv, n_arr, n_rv, old_busy, old_done, w_start, w_clr;
    logic        started = 1'b0, prev_rst = 1'b0;
    int          m_left = 0;

    function automatic logic [31:0] gcd_ref(input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != 32'd0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Cycles spent busy: one per subtraction plus the terminating step.
    function automatic int calc_cycles(input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] a, b;
        int n;
        a = a_in;
        b = b_in;
        n = 1;
        while (!(a == 32'd0 || b == 32'd0 || a == b)) begin
            if (a > b) a = a - b;
            else b = b - a;
            n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] model_rd(input logic [1:0] sel);
        case (sel)
            2'd0:    return m_a;
            2'd1:    return m_b;
            2'd2:    return {28'd0, m_busy, m_done, m_ie, 1'b0};
            default: return m_result;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: check this cycle against the model, then advance the model.
    initial begin
        forever begin
            @(negedge ACLK);
            if (started) begin
                if (prev_rst) begin
                    chk("reset_outputs", {26'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
                                          S_AXI_ARREADY, S_AXI_RVALID, irq}, 32'd0);
                    chk("reset_rdata", S_AXI_RDATA, 32'd0);
                end
                chk("awready", {31'd0, S_AXI_AWREADY}, {31'd0, m_awr});
                chk("wready",  {31'd0, S_AXI_WREADY},  {31'd0, m_awr});
                chk("bvalid",  {31'd0, S_AXI_BVALID},  {31'd0, m_bv});
                chk("arready", {31'd0, S_AXI_ARREADY}, {31'd0, m_arr});
                chk("rvalid",  {31'd0, S_AXI_RVALID},  {31'd0, m_rv});
                chk("irq",     {31'd0, irq},           {31'd0, m_done & m_ie});
                if (S_AXI_BVALID) chk("bresp", {30'd0, S_AXI_BRESP}, 32'd0);
                if (S_AXI_RVALID) begin
                    chk("rdata", S_AXI_RDATA, m_rexp);
                    chk("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
                    if (S_AXI_RREADY && lit_en) chk("rdata_literal", S_AXI_RDATA, lit_val);
                end
                if (drv_timeouts != seen_timeouts) begin
                    chk("handshake_timeout", drv_timeouts, seen_timeouts);
                    seen_timeouts = drv_timeouts;
                end
            end
            if (ARESET) begin
                started = 1'b1;
                prev_rst = 1'b1;
                m_a = 32'd0; m_b = 32'd0; m_result = 32'd0; m_pend = 32'd0; m_rexp = 32'd0;
                m_ie = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
                m_awr = 1'b0; m_bv = 1'b0; m_arr = 1'b0; m_rv = 1'b0;
            end else begin
                prev_rst = 1'b0;
                old_busy = m_busy;
                old_done = m_done;
                n_awr = S_AXI_AWVALID & S_AXI_WVALID & ~m_awr & ~m_bv;
                n_arr = S_AXI_ARVALID & ~m_arr & ~m_rv;
                n_bv  = m_awr ? 1'b1 : ((m_bv & S_AXI_BREADY) ? 1'b0 : m_bv);
                n_rv  = m_arr ? 1'b1 : ((m_rv & S_AXI_RREADY) ? 1'b0 : m_rv);
                if (m_arr) m_rexp = model_rd(S_AXI_ARADDR[3:2]);
                w_start = 1'b0;
                w_clr = 1'b0;
                if (m_awr) begin
                    case (S_AXI_AWADDR[3:2])
                        2'd0: for (int i = 0; i < 4; i++) if (S_AXI_WSTRB[i]) m_a[8*i +: 8] = S_AXI_WDATA[8*i +: 8];
                        2'd1: for (int i = 0; i < 4; i++) if (S_AXI_WSTRB[i]) m_b[8*i +: 8] = S_AXI_WDATA[8*i +: 8];
                        2'd2: if (S_AXI_WSTRB[0]) begin
                            m_ie = S_AXI_WDATA[1];
                            w_start = S_AXI_WDATA[0];
                            w_clr = S_AXI_WDATA[2];
                        end
                        default: ;
                    endcase
                end
                if (old_busy) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_result = m_pend;
                    end
                end
                if (w_start && !old_busy) begin
                    m_busy = 1'b1;
                    m_done = 1'b0;
                    m_left = calc_cycles(m_a, m_b);
                    m_pend = gcd_ref(m_a, m_b);
                end else if (w_clr && old_done) begin
                    m_done = 1'b0;
                end
                m_awr = n_awr; m_bv = n_bv; m_arr = n_arr; m_rv = n_rv;
            end
        end
    end

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return S_AXI_AWREADY;
            1:       return S_AXI_BVALID;
            2:       return S_AXI_ARREADY;
            default: return S_AXI_RVALID;
        endcase
    endfunction

    // Returns at the falling edge of the first cycle in which the signal is high.
    task automatic wait_high(input int sel);
        int n;
        n = 0;
        @(negedge ACLK);
        while (!sig_of(sel)) begin
            if (n == 50) begin
                drv_timeouts++;
                break;
            end
            @(negedge ACLK);
            n++;
        end
    endtask

    task automatic aw_w_send(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int wdelay);
        S_AXI_AWADDR = addr;
        S_AXI_WDATA = data;
        S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1'b1;
        repeat (wdelay) begin
            @(posedge ACLK);
            #1;
        end
        S_AXI_WVALID = 1'b1;
        wait_high(0);
        @(posedge ACLK);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID = 1'b0;
    endtask

    task automatic b_recv(input int hold);
        wait_high(1);
        repeat (hold) @(negedge ACLK);
        @(posedge ACLK);
        #1;
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK);
        #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        aw_w_send(addr, data, strb, 0);
        b_recv(0);
    endtask

    task automatic rd(input logic [3:0] addr, input logic le, input logic [31:0] lv,
                      input int rhold, output logic [31:0] data);
        lit_en = le;
        lit_val = lv;
        S_AXI_ARADDR = addr;
        S_AXI_ARVALID = 1'b1;
        wait_high(2);
        @(posedge ACLK);
        #1;
        S_AXI_ARVALID = 1'b0;
        wait_high(3);
        repeat (rhold) @(negedge ACLK);
        @(posedge ACLK);
        #1;
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        data = S_AXI_RDATA;
        @(posedge ACLK);
        #1;
        S_AXI_RREADY = 1'b0;
        lit_en = 1'b0;
    endtask

    task automatic wait_done();
        logic [31:0] d;
        int n;
        d = 32'd0;
        n = 0;
        while (d[2] == 1'b0 && n < 800) begin
            rd(ADDR_CTRL, 1'b0, 32'd0, 0, d);
            n++;
        end
        if (d[2] == 1'b0) drv_timeouts++;
    endtask

    task automatic run_gcd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] d;
        wr(ADDR_A, a, 4'hF);
        wr(ADDR_B, b, 4'hF);
        wr(ADDR_CTRL, 32'h1, 4'hF);
        wait_done();
        rd(ADDR_RESULT, 1'b1, exp, 0, d);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    // Stimulus.
    initial begin
        logic [31:0] d, ra, rb, rk;
        logic        ie_b;
        repeat (3) @(posedge ACLK);
        #1;
        ARESET = 1'b0;

        rd(ADDR_A, 1'b1, 32'd0, 0, d);
        rd(ADDR_B, 1'b1, 32'd0, 0, d);
        rd(ADDR_CTRL, 1'b1, 32'd0, 0, d);
        rd(ADDR_RESULT, 1'b1, 32'd0, 0, d);

        wr(ADDR_A, 32'd48, 4'hF);
        wr(ADDR_B, 32'd18, 4'hF);
        wr(ADDR_CTRL, 32'h3, 4'hF);
        rd(ADDR_CTRL, 1'b1, 32'h0000000A, 0, d);
        wait_done();
        rd(ADDR_RESULT, 1'b1, 32'd6, 0, d);
        rd(ADDR_CTRL, 1'b1, 32'h6, 0, d);
        wr(ADDR_CTRL, 32'h4, 4'hF);
        rd(ADDR_CTRL, 1'b1, 32'h0, 0, d);

        run_gcd(32'd0, 32'd7, 32'd7);
        run_gcd(32'd0, 32'd0, 32'd0);
        run_gcd(32'h10000, 32'h10000, 32'h10000);
        run_gcd(32'd13, 32'd1, 32'd1);
        // Clear attempt with byte 0 disabled must leave DONE set.
        wr(ADDR_CTRL, 32'h4, 4'b0010);
        rd(ADDR_CTRL, 1'b1, 32'h4, 0, d);

        wr(ADDR_A, 32'd0, 4'hF);
        wr(ADDR_A, 32'hAABBCCDD, 4'b0010);
        rd(ADDR_A, 1'b1, 32'h0000CC00, 0, d);

        // Second write presented while the first response is held off.
        aw_w_send(ADDR_B, 32'h11, 4'hF, 0);
        S_AXI_AWADDR = ADDR_B;
        S_AXI_WDATA = 32'h22;
        S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID = 1'b1;
        b_recv(10);
        wait_high(0);
        @(posedge ACLK);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID = 1'b0;
        b_recv(0);
        rd(ADDR_B, 1'b1, 32'h22, 0, d);
        rd(ADDR_A, 1'b1, 32'h0000CC00, 6, d);

        wr(ADDR_A, 32'd1000, 4'hF);
        wr(ADDR_B, 32'd1, 4'hF);
        wr(ADDR_CTRL, 32'h3, 4'hF);
        repeat (20) @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        rd(ADDR_A, 1'b1, 32'd0, 0, d);
        rd(ADDR_B, 1'b1, 32'd0, 0, d);
        rd(ADDR_CTRL, 1'b1, 32'd0, 0, d);
        rd(ADDR_RESULT, 1'b1, 32'd0, 0, d);

        wr(ADDR_A, 32'd1000, 4'hF);
        wr(ADDR_B, 32'd3, 4'hF);
        wr(ADDR_CTRL, 32'h1, 4'hF);
        wr(ADDR_A, 32'd9, 4'hF);
        wr(ADDR_CTRL, 32'h1, 4'hF);
        wait_done();
        rd(ADDR_RESULT, 1'b1, 32'd1, 0, d);
        rd(ADDR_A, 1'b1, 32'd9, 0, d);

        for (int it = 0; it < 25; it++) begin
            ra = 32'($urandom_range(0, 300));
            rb = 32'($urandom_range(0, 300));
            rk = 32'($urandom_range(1, 1048576));
            ie_b = 1'($urandom_range(0, 1));
            aw_w_send(ADDR_A, ra * rk, 4'hF, int'($urandom_range(0, 3)));
            b_recv(int'($urandom_range(0, 3)));
            aw_w_send(ADDR_B, rb * rk, 4'hF, int'($urandom_range(0, 3)));
            b_recv(int'($urandom_range(0, 3)));
            wr(ADDR_CTRL, {30'd0, ie_b, 1'b1}, 4'hF);
            wait_done();
            rd(ADDR_RESULT, 1'b0, 32'd0, int'($urandom_range(0, 3)), d);
            if ($urandom_range(0, 1) == 1) begin
                wr(ADDR_A, $urandom, 4'($urandom_range(0, 15)));
                rd(ADDR_A, 1'b0, 32'd0, 0, d);
            end
            if ($urandom_range(0, 1) == 1) begin
                wr(ADDR_CTRL, {29'd0, 1'b1, ie_b, 1'b0}, 4'hF);
                rd(ADDR_CTRL, 1'b0, 32'd0, 0, d);
            end
        end

        repeat (5) @(posedge ACLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_axil_slave.md
Name: gcd_axil_slave

Overview:
- AXI4-Lite slave register file plus an iterative subtract-based GCD engine.
- This is the responder the team's AXI4-Lite master VIP drives in the GCD IP block design; it sits behind S00_AXI.
- Software writes operands A and B, sets START, polls DONE or waits for the interrupt, then reads RESULT.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; decoded on ADDR[3:2], ADDR[1:0] ignored.

Ports:
- ACLK  in  1  sole clock; all logic on its rising edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- irq  out  1  level interrupt = DONE & IE.

Behaviour:
- Register map:
  - 0x0 A: RW, 32 bits.
  - 0x4 B: RW, 32 bits.
  - 0x8 CTRL: bit0 START (write-1 pulse, reads 0); bit1 IE (RW); bit2 DONE (RO, write-1-to-clear); bit3 BUSY (RO); all other bits read 0.
  - 0xC RESULT: RO; writes accepted with OKAY and ignored.
- Reset (ARESET=1 at a clock edge): every output 0, all registers 0, FSM to IDLE. Reset mid-CALC aborts the computation with no residual DONE or irq.
- Write channel:
  - A write is accepted in cycle N when AWVALID and WVALID are both 1, AWREADY=0, and BVALID=0.
  - AWREADY and WREADY are high together for exactly cycle N+1, and the register is updated at the end of N+1.
  - BVALID rises in N+2 and holds until BREADY is sampled high.
  - One outstanding write only. AW without W, or W without AW, waits.
  - WSTRB[i] gates byte i of A, B, and CTRL.IE. START and DONE-clear are acted on only if WSTRB[0]=1.
- Read channel:
  - A read is accepted when ARVALID=1, ARREADY=0, and RVALID=0. ARREADY pulses for 1 cycle.
  - RDATA is registered and RVALID rises the next cycle. RDATA is stable while RVALID=1 && RREADY=0. One outstanding read only.
- Simultaneous read and write are independent. A read of a register written in the same cycle returns the old value.
- GCD FSM has three states: IDLE, CALC, DONE.
  - IDLE or DONE, START written: latch x<=A and y<=B, BUSY=1, DONE=0, go to CALC.
  - CALC, one step per cycle:
    - if x==0: RESULT<=y
    - else if y==0 or x==y: RESULT<=x
    - in any of these three cases: BUSY=0, DONE=1, go to DONE.
    - else if x>y: x<=x-y
    - else: y<=y-x
  - START while BUSY is ignored and does not restart.
  - Writes to A/B while BUSY update the registers but not the latched x/y.
- DONE is sticky until cleared by W1C to CTRL bit2 or by a new START. If the same write sets START and clears DONE, START wins: BUSY=1, DONE=0.
- RESULT holds its last value until the next completion. gcd(0,0)=0.
- irq is combinational from registered DONE & IE, so it has no extra latency.

Test Plan:
- Reset then read 0x0/0x4/0x8/0xC -> all 0x00000000, RRESP=0, irq=0.
- Write A=48, B=18, CTRL=0x3 -> BUSY read as 1, DONE within 5 cycles of CALC entry, RESULT=0x6, CTRL=0x6, irq=1; then write CTRL=0x4 -> DONE=0, irq=0.
- Edge operands:
  - A=0, B=7 -> RESULT=7.
  - A=0, B=0 -> RESULT=0.
  - A=B=0x10000 -> RESULT=0x10000 after 1 CALC cycle.
  - A=13, B=1 -> RESULT=1.
- A=0, then write 0xAABBCCDD with WSTRB=0b0010 -> A reads 0x0000CC00.
- Hold BREADY=0 for 10 cycles after a write -> BVALID stays 1, a second AW/W pair is not accepted until B completes. Hold RREADY=0 -> RDATA stable.
- Two edge-case checks:
  - Start A=1000, B=1, assert ARESET mid-CALC -> next reads are all 0 and irq=0.
  - Start while BUSY -> computation continues from the original operands.
